vecalu_seq: RTL and testbench



---
 rtl/vecalu_seq_if.sv | 31 +++
 rtl/vecalu_seq.sv | 101 ++++++++++
 tb/tb_vecalu_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vecalu_seq_if.sv
// vecalu_seq_if: request/read/writeback bundle between issue stage, vecalu_seq and VRF/ALU
//   master: issue side, drives req_valid/req_op/req_vl/stall, observes everything else
//   slave : the sequencer, drives req_ready, rd_*, alu_ctrl, wb_*, done, err
interface vecalu_seq_if #(
    parameter int VLEN  = 64,
    parameter int LANES = 8
);
    localparam int VW = $clog2(VLEN) + 1;
    localparam int GW = $clog2(VLEN / LANES);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [VW-1:0]    req_vl;
    logic             stall;
    logic             rd_valid;
    logic [GW-1:0]    rd_grp;
    logic [3:0]       alu_ctrl;
    logic             wb_valid;
    logic [GW-1:0]    wb_grp;
    logic [LANES-1:0] wb_mask;
    logic             done;
    logic             err;
    modport master (
        output req_valid, req_op, req_vl, stall,
        input  req_ready, rd_valid, rd_grp, alu_ctrl, wb_valid, wb_grp, wb_mask, done, err
    );
    modport slave (
        input  req_valid, req_op, req_vl, stall,
        output req_ready, rd_valid, rd_grp, alu_ctrl, wb_valid, wb_grp, wb_mask, done, err
    );
endinterface

// File: rtl/vecalu_seq.sv
// vecalu_seq: strip-mines one vector ALU op of vl elements into LANES-wide groups
//   clk, rst (sync, active-high); bus: vecalu_seq_if.slave (request handshake, group
//   reads, ALU control, writeback strobes/mask, done/err).
//   Optional VECALU_SEQ_PERF_EN adds perf_busy / perf_ops 32-bit counters.
module vecalu_seq #(
    parameter int VLEN  = 64,
    parameter int ELEN  = 32,
    parameter int LANES = 8
) (
    input  logic        clk,
    input  logic        rst,
    vecalu_seq_if.slave bus
`ifdef VECALU_SEQ_PERF_EN
    ,
    output logic [31:0] perf_busy,
    output logic [31:0] perf_ops
`endif
);
    localparam int VW = $clog2(VLEN) + 1;
    localparam int GW = $clog2(VLEN / LANES);
    if (LANES < 1 || (LANES & (LANES - 1)) != 0 || VLEN % LANES != 0 || ELEN < 1) begin : g_bad_cfg
        $error("vecalu_seq: illegal VLEN/ELEN/LANES");
    end
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
    state_t           st, nxt;
    logic [3:0]       op_q;
    logic [VW-1:0]    vl_q;
    logic [GW-1:0]    g;
    logic [LANES-1:0] mask_n, wb_m;
    logic [GW-1:0]    wb_g;
    logic             accept, bad, last, rd_v, wb_v, done_w, err_w;
    assign bus.req_ready = st == IDLE || st == FIN;
    assign accept        = bus.req_valid && bus.req_ready;
    // illegal opcode and empty vector both skip straight to FIN
    assign bad           = op_q > 4'd9 || vl_q == '0;
    assign last          = (int'(g) + 1) * LANES >= int'(vl_q);
    assign done_w        = st == FIN;
    assign err_w         = done_w && op_q > 4'd9;
    assign bus.done      = done_w;
    assign bus.err       = err_w;
    assign bus.alu_ctrl  = st == IDLE ? 4'd0 : op_q;
    assign bus.rd_valid  = rd_v;
    assign bus.rd_grp    = rd_v ? g : '0;
    assign bus.wb_valid  = wb_v;
    assign bus.wb_grp    = wb_g;
    assign bus.wb_mask   = wb_m;
    // lane i of group g covers element g*LANES+i; full groups come out all ones
    always_comb begin
        mask_n = '0;
        for (int i = 0; i < LANES; i++) mask_n[i] = int'(g) * LANES + i < int'(vl_q);
    end
    always_comb begin
        nxt  = st;
        rd_v = 1'b0;
        case (st)
            IDLE:  nxt = accept ? ISSUE : IDLE;
            ISSUE: begin
                rd_v = !bad && !bus.stall;
                nxt  = bad ? FIN : (rd_v && last) ? DRAIN : ISSUE;
            end
            DRAIN: nxt = FIN;
            FIN:   nxt = accept ? ISSUE : IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            op_q <= '0;
            vl_q <= '0;
            g    <= '0;
            wb_v <= 1'b0;
            wb_g <= '0;
            wb_m <= '0;
        end else begin
            st <= nxt;
            if (accept) begin
                op_q <= bus.req_op;
                vl_q <= bus.req_vl;
                g    <= '0;
            end else if (rd_v && !last) begin
                g <= g + 1'b1;
            end
            // one-cycle read latency: the writeback replays the read group
            wb_v <= rd_v;
            wb_g <= rd_v ? g : '0;
            wb_m <= rd_v ? mask_n : '0;
        end
    end
`ifdef VECALU_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy <= '0;
            perf_ops  <= '0;
        end else begin
            perf_busy <= perf_busy + 32'(st != IDLE);
            perf_ops  <= perf_ops + 32'(done_w && !err_w);
        end
    end
`endif
endmodule

// File: tb/tb_vecalu_seq.sv
// tb_vecalu_seq: directed self-checking bench for vecalu_seq
module tb_vecalu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    always #5 clk = ~clk;
    vecalu_seq_if #(.VLEN(64), .LANES(8)) bus ();
`ifdef VECALU_SEQ_PERF_EN
    logic [31:0] perf_busy, perf_ops;
    vecalu_seq #(.VLEN(64), .ELEN(32), .LANES(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .perf_busy(perf_busy), .perf_ops(perf_ops));
`else
    vecalu_seq #(.VLEN(64), .ELEN(32), .LANES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
    function automatic logic [22:0] snap();
        return {bus.req_ready, bus.rd_valid, bus.rd_grp, bus.alu_ctrl, bus.wb_valid,
                bus.wb_grp, bus.wb_mask, bus.done, bus.err};
    endfunction
    function automatic logic [22:0] mk(input logic rr, input logic rv, input logic [2:0] rg,
                                       input logic [3:0] ac, input logic wv, input logic [2:0] wg,
                                       input logic [7:0] wm, input logic dn, input logic er);
        return {rr, rv, rg, ac, wv, wg, wm, dn, er};
    endfunction
    task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_chk(input string tag);
        step();
        #1;
        chk(tag, snap(), mk(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
    endtask
    // Accepts op in the current cycle (T), then checks every cycle up to the
    // hand-computed done cycle T+dn; returns while still in the done cycle.
    task automatic run_op(input string name, input logic [3:0] op, input logic [6:0] vl,
                          input int g_n, input logic [7:0] lmask, input int dn,
                          input logic er, input int sa, input int sn);
        int         r  = 0;
        logic       pv = 1'b0;
        logic [2:0] pg = 3'd0;
        logic       ev;
        logic [2:0] eg;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_vl    = vl;
        #1;
        chk({name, " accept"}, {22'd0, bus.req_ready}, 23'd1);
        for (int k = 1; k <= dn; k++) begin
            step();
            if (k == 1) begin
                bus.req_valid = 1'b0;
                bus.req_op    = 4'hF;
                bus.req_vl    = 7'd5;
            end
            bus.stall = k >= sa && k < sa + sn;
            #1;
            ev = g_n > 0 && r < g_n && !bus.stall;
            eg = ev ? 3'(r) : 3'd0;
            chk($sformatf("%s T+%0d", name, k), snap(),
                mk(k == dn, ev, eg, op, pv, pv ? pg : 3'd0,
                   pv ? ((int'(pg) == g_n - 1) ? lmask : 8'hFF) : 8'h00,
                   k == dn, k == dn && er));
            if (ev) r++;
            pv = ev;
            pg = eg;
        end
        bus.stall = 1'b0;
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_vl    = 7'd0;
        bus.stall     = 1'b0;
        step();
        step();
        #1;
        chk("reset", snap(), mk(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
        rst = 1'b0;
        idle_chk("idle0");
        run_op("add64", 4'd0, 7'd64, 8, 8'hFF, 10, 1'b0, 0, 0);
        idle_chk("idle1");
        run_op("sub13", 4'd1, 7'd13, 2, 8'h1F, 4, 1'b0, 0, 0);
        idle_chk("idle2");
        run_op("xor64_stall", 4'd4, 7'd64, 8, 8'hFF, 13, 1'b0, 3, 3);
        run_op("sltu9_b2b", 4'd9, 7'd9, 2, 8'h01, 4, 1'b0, 0, 0);
        run_op("sra8_b2b", 4'd8, 7'd8, 1, 8'hFF, 3, 1'b0, 0, 0);
        idle_chk("idle3");
        run_op("illegal_c", 4'hC, 7'd32, 0, 8'h00, 2, 1'b1, 0, 0);
        run_op("illegal_a", 4'hA, 7'd64, 0, 8'h00, 2, 1'b1, 0, 0);
        idle_chk("idle4");
        run_op("and_vl0", 4'd2, 7'd0, 0, 8'h00, 2, 1'b0, 0, 0);
        idle_chk("idle5");
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd0;
        bus.req_vl    = 7'd64;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst_pre", snap(), mk(1'b0, 1'b1, 3'd3, 4'd0, 1'b1, 3'd2, 8'hFF, 1'b0, 1'b0));
        step();
        rst = 1'b0;
        #1;
        chk("rst_abort", snap(), mk(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) idle_chk($sformatf("rst_quiet%0d", i));
        run_op("or20_after_rst", 4'd3, 7'd20, 3, 8'h0F, 5, 1'b0, 0, 0);
        idle_chk("idle6");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
